// File: rtl/issue_queue_nxm.sv
// ---------------------------------------------------------------------------
// issue_queue_nxm
// Out-of-order issue queue. Accepts up to DISP renamed uops per cycle into
// DEPTH slots, wakes source operands from WAKE writeback tag ports, and issues
// up to ISSUE ready uops per cycle (lowest slot index first, port 0 lowest).
// Uops whose branch mask intersects i_BrKill are flushed.
//
// Uop record layout (LSB first): p1, p2, val, pr1, pr2, prd, Tag, BrM, UOP[6:0]
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset
//   i_inst    DISP dispatch uops, slot k at [k*WIDTH +: WIDTH]
//   i_en      dispatch request
//   o_ready   queue can take a full DISP group (registered)
//   i_wdest   WAKE wakeup destination tags
//   i_wvalid  per-port wakeup valid
//   i_BrKill  mispredicted branch bits
//   i_BrClr   resolved branch bits (only with IQ_BRCLEAR_EN)
//   o_inst    ISSUE issued uops, port j at [j*WIDTH +: WIDTH] (held when idle)
//   o_valid   per-port issue valid
//   o_count   occupied slot count
//
// Build option: define IQ_BRCLEAR_EN to add the i_BrClr port, which clears
// branch-mask bits of held and incoming uops after the kill check.
// ---------------------------------------------------------------------------
module issue_queue_nxm #(
    parameter int WIDTH_REG = 3,
    parameter int WIDTH_TAG = 3,
    parameter int WIDTH_BRM = 3,
    parameter int DEPTH     = 8,
    parameter int DISP      = 4,
    parameter int ISSUE     = 2,
    parameter int WAKE      = 4,
    localparam int WIDTH    = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DISP*WIDTH-1:0]      i_inst,
    input  logic                       i_en,
    output logic                       o_ready,
    input  logic [WAKE*WIDTH_REG-1:0]  i_wdest,
    input  logic [WAKE-1:0]            i_wvalid,
    input  logic [WIDTH_BRM-1:0]       i_BrKill,
`ifdef IQ_BRCLEAR_EN
    input  logic [WIDTH_BRM-1:0]       i_BrClr,
`endif
    output logic [ISSUE*WIDTH-1:0]     o_inst,
    output logic [ISSUE-1:0]           o_valid,
    output logic [CW-1:0]              o_count
);

    // Field offsets inside a uop record
    localparam int P1_B  = 0;
    localparam int P2_B  = 1;
    localparam int VAL_B = 2;
    localparam int PR1_L = 3;
    localparam int PR2_L = 3 + WIDTH_REG;
    localparam int BRM_L = 3 + 3*WIDTH_REG + WIDTH_TAG;

    logic [WIDTH-1:0]       slots_r [DEPTH];
    logic [WIDTH-1:0]       slots_n_s [DEPTH];
    logic [ISSUE*WIDTH-1:0] inst_n_s;
    logic [ISSUE-1:0]       valid_n_s;
    logic [CW-1:0]          count_n_s;
    logic                   ready_n_s;
    logic [DEPTH-1:0]       free_s;
    logic                   accept_s;
    logic                   placed_s;
    logic                   sel_s;
    logic                   kill_s;
    logic [WIDTH-1:0]       in_uop_s;
    logic [WIDTH_BRM-1:0]   brclr_s;
    int                     sel_cnt_s;

`ifdef IQ_BRCLEAR_EN
    assign brclr_s = i_BrClr;
`else
    assign brclr_s = {WIDTH_BRM{1'b0}};
`endif

    // Sets p1/p2 of a uop whose source tag matches any valid wakeup port
    function automatic logic [WIDTH-1:0] apply_wake(
        input logic [WIDTH-1:0]          e,
        input logic [WAKE*WIDTH_REG-1:0] wd,
        input logic [WAKE-1:0]           wv
    );
        logic [WIDTH-1:0] r;
        r = e;
        for (int w = 0; w < WAKE; w++) begin
            if (wv[w] && (e[PR1_L +: WIDTH_REG] == wd[w*WIDTH_REG +: WIDTH_REG])) begin
                r[P1_B] = 1'b1;
            end else begin
                r[P1_B] = r[P1_B];
            end
            if (wv[w] && (e[PR2_L +: WIDTH_REG] == wd[w*WIDTH_REG +: WIDTH_REG])) begin
                r[P2_B] = 1'b1;
            end else begin
                r[P2_B] = r[P2_B];
            end
        end
        return r;
    endfunction

    // Clears resolved-branch bits from the mask of a uop
    function automatic logic [WIDTH-1:0] clear_brm(
        input logic [WIDTH-1:0]     e,
        input logic [WIDTH_BRM-1:0] clr
    );
        logic [WIDTH-1:0] r;
        r = e;
        r[BRM_L +: WIDTH_BRM] = e[BRM_L +: WIDTH_BRM] & ~clr;
        return r;
    endfunction

    // True when a present uop depends on a mispredicted branch
    function automatic logic is_killed(
        input logic [WIDTH-1:0]     e,
        input logic [WIDTH_BRM-1:0] kill
    );
        return e[VAL_B] && ((e[BRM_L +: WIDTH_BRM] & kill) != {WIDTH_BRM{1'b0}});
    endfunction

    // Next-state: select/issue, kill, wakeup, branch clear, dispatch, count
    always_comb begin
        inst_n_s  = o_inst;
        valid_n_s = {ISSUE{1'b0}};
        sel_cnt_s = 0;
        free_s    = {DEPTH{1'b0}};
        placed_s  = 1'b0;
        sel_s     = 1'b0;
        kill_s    = 1'b0;
        in_uop_s  = {WIDTH{1'b0}};
        count_n_s = {CW{1'b0}};
        accept_s  = i_en & o_ready;

        // Held slots: pick the lowest ready slots; killed picks still use up a port
        for (int i = 0; i < DEPTH; i++) begin
            kill_s    = is_killed(slots_r[i], i_BrKill);
            free_s[i] = ~slots_r[i][VAL_B];
            if (slots_r[i][VAL_B] && slots_r[i][P1_B] && slots_r[i][P2_B] && (sel_cnt_s < ISSUE)) begin
                sel_s = 1'b1;
                for (int j = 0; j < ISSUE; j++) begin
                    if ((j == sel_cnt_s) && !kill_s) begin
                        valid_n_s[j]                 = 1'b1;
                        inst_n_s[j*WIDTH +: WIDTH]   = clear_brm(slots_r[i], brclr_s);
                    end else begin
                        valid_n_s[j]                 = valid_n_s[j];
                    end
                end
                sel_cnt_s = sel_cnt_s + 1;
            end else begin
                sel_s = 1'b0;
            end
            if (slots_r[i][VAL_B] && !sel_s && !kill_s) begin
                slots_n_s[i] = clear_brm(apply_wake(slots_r[i], i_wdest, i_wvalid), brclr_s);
            end else begin
                slots_n_s[i] = {WIDTH{1'b0}};
            end
        end

        // Dispatch into slots that were free before this edge; o_ready
        // guarantees at least DISP of them exist
        for (int k = 0; k < DISP; k++) begin
            in_uop_s = i_inst[k*WIDTH +: WIDTH];
            placed_s = 1'b0;
            if (accept_s && in_uop_s[VAL_B] && !is_killed(in_uop_s, i_BrKill)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!placed_s && free_s[i]) begin
                        slots_n_s[i] = clear_brm(apply_wake(in_uop_s, i_wdest, i_wvalid), brclr_s);
                        free_s[i]    = 1'b0;
                        placed_s     = 1'b1;
                    end else begin
                        placed_s     = placed_s;
                    end
                end
            end else begin
                placed_s = 1'b0;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            count_n_s = count_n_s + CW'(slots_n_s[i][VAL_B]);
        end
        ready_n_s = (count_n_s <= CW'(DEPTH - DISP));
    end

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= {WIDTH{1'b0}};
            end
            o_inst  <= {(ISSUE*WIDTH){1'b0}};
            o_valid <= {ISSUE{1'b0}};
            o_count <= {CW{1'b0}};
            o_ready <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= slots_n_s[i];
            end
            o_inst  <= inst_n_s;
            o_valid <= valid_n_s;
            o_count <= count_n_s;
            o_ready <= ready_n_s;
        end
    end

endmodule

// File: tb/tb_issue_queue_nxm.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_nxm
// Directed bench for issue_queue_nxm (DEPTH=8, DISP=4, ISSUE=2, WAKE=4,
// widths 3). A vector table covers dispatch/issue/fill/drain; hand-written
// sequences cover wakeup latency, branch kill, branch clear and async reset.
// ---------------------------------------------------------------------------
module tb_issue_queue_nxm;

    localparam int W  = 25;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic [4*W-1:0]  inst;
    logic            en;
    logic            ready;
    logic [11:0]     wdest;
    logic [3:0]      wvalid;
    logic [2:0]      brkill;
    logic [2:0]      brclr;
    logic [2*W-1:0]  oinst;
    logic [1:0]      ovalid;
    logic [CW-1:0]   count;

    int checks   = 0;
    int failures = 0;

    issue_queue_nxm dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_inst   (inst),
        .i_en     (en),
        .o_ready  (ready),
        .i_wdest  (wdest),
        .i_wvalid (wvalid),
        .i_BrKill (brkill),
`ifdef IQ_BRCLEAR_EN
        .i_BrClr  (brclr),
`endif
        .o_inst   (oinst),
        .o_valid  (ovalid),
        .o_count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           en;
        logic [4*W-1:0] inst;
        logic [11:0]    wdest;
        logic [3:0]     wvalid;
        logic [CW-1:0]  count;
        logic [1:0]     valid;
        logic           ready;
        logic [W-1:0]   i0;
        logic [W-1:0]   i1;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [W-1:0] mk(
        input logic [6:0] uop, input logic [2:0] brm, input logic [2:0] tag,
        input logic [2:0] prd, input logic [2:0] pr2, input logic [2:0] pr1,
        input logic val, input logic p2, input logic p1
    );
        return {uop, brm, tag, prd, pr2, pr1, val, p2, p1};
    endfunction

    function automatic vec_t mkv(
        input logic en_v, input logic [4*W-1:0] inst_v, input logic [11:0] wd_v,
        input logic [3:0] wv_v, input logic [CW-1:0] cnt_v, input logic [1:0] val_v,
        input logic rdy_v, input logic [W-1:0] i0_v, input logic [W-1:0] i1_v
    );
        vec_t v;
        v.en = en_v; v.inst = inst_v; v.wdest = wd_v; v.wvalid = wv_v;
        v.count = cnt_v; v.valid = val_v; v.ready = rdy_v; v.i0 = i0_v; v.i1 = i1_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; inst = '0; wdest = '0; wvalid = 4'b0000; brkill = 3'b000; brclr = 3'b000;
    endtask

    task automatic chk_state(input string name, input logic [CW-1:0] c,
                             input logic [1:0] v, input logic r);
        chk({name, "_count"}, 64'(count),  64'(c));
        chk({name, "_valid"}, 64'(ovalid), 64'(v));
        chk({name, "_ready"}, 64'(ready),  64'(r));
    endtask

    logic [W-1:0] a [4];
    logic [W-1:0] f [4];
    logic [W-1:0] g [4];
    logic [W-1:0] h [4];
    logic [W-1:0] wu, k0, k1, k2, cu, r0;
    logic [W-1:0] zero_u;

    initial begin
        zero_u = '0;
        for (int k = 0; k < 4; k++) begin
            a[k] = mk(7'(k + 1),    3'b000, 3'(k), 3'(k), 3'd1, 3'd2, 1'b1, 1'b1, 1'b1);
            f[k] = mk(7'(k + 16),   3'b000, 3'(k), 3'(k), 3'd1, 3'd5, 1'b1, 1'b1, 1'b0);
            g[k] = mk(7'(k + 32),   3'b000, 3'(k), 3'(k), 3'd1, 3'd5, 1'b1, 1'b1, 1'b0);
            h[k] = mk(7'(k + 48),   3'b000, 3'(k), 3'(k), 3'd1, 3'd5, 1'b1, 1'b1, 1'b0);
        end

        vecs[0]  = mkv(1'b1, {a[3], a[2], a[1], a[0]}, 12'h000, 4'b0000, 4'd4, 2'b00, 1'b1, zero_u, zero_u);
        vecs[1]  = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd2, 2'b11, 1'b1, a[0], a[1]);
        vecs[2]  = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd0, 2'b11, 1'b1, a[2], a[3]);
        vecs[3]  = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd0, 2'b00, 1'b1, zero_u, zero_u);
        vecs[4]  = mkv(1'b1, {f[3], f[2], f[1], f[0]}, 12'h000, 4'b0000, 4'd4, 2'b00, 1'b1, zero_u, zero_u);
        vecs[5]  = mkv(1'b1, {g[3], g[2], g[1], g[0]}, 12'h000, 4'b0000, 4'd8, 2'b00, 1'b0, zero_u, zero_u);
        vecs[6]  = mkv(1'b1, {h[3], h[2], h[1], h[0]}, 12'h000, 4'b0000, 4'd8, 2'b00, 1'b0, zero_u, zero_u);
        vecs[7]  = mkv(1'b0, '0, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 4'd8, 2'b00, 1'b0, zero_u, zero_u);
        vecs[8]  = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd6, 2'b11, 1'b0, f[0] | 25'd1, f[1] | 25'd1);
        vecs[9]  = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd4, 2'b11, 1'b1, f[2] | 25'd1, f[3] | 25'd1);
        vecs[10] = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd2, 2'b11, 1'b1, g[0] | 25'd1, g[1] | 25'd1);
        vecs[11] = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd0, 2'b11, 1'b1, g[2] | 25'd1, g[3] | 25'd1);
        vecs[12] = mkv(1'b0, '0, 12'h000, 4'b0000, 4'd0, 2'b00, 1'b1, zero_u, zero_u);

        // Reset state
        idle();
        rst = 1'b1;
        tick();
        chk_state("reset", 4'd0, 2'b00, 1'b1);
        chk("reset_inst", 64'(oinst), 64'd0);
        rst = 1'b0;

        // Table: dispatch/issue order, fill to full, dropped group, drain
        for (int i = 0; i < 13; i++) begin
            idle();
            en = vecs[i].en; inst = vecs[i].inst; wdest = vecs[i].wdest; wvalid = vecs[i].wvalid;
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].count, vecs[i].valid, vecs[i].ready);
            if (vecs[i].valid[0]) chk($sformatf("vec%0d_inst0", i), 64'(oinst[0 +: W]), 64'(vecs[i].i0));
            if (vecs[i].valid[1]) chk($sformatf("vec%0d_inst1", i), 64'(oinst[W +: W]), 64'(vecs[i].i1));
        end

        // Wakeup: tag in cycle N -> issue visible in cycle N+2; wvalid=0 does nothing
        wu = mk(7'h50, 3'b000, 3'd3, 3'd4, 3'd1, 3'd6, 1'b1, 1'b1, 1'b0);
        idle(); en = 1'b1; inst = {zero_u, zero_u, zero_u, wu};
        tick();
        chk_state("wk_disp", 4'd1, 2'b00, 1'b1);
        idle(); wdest = {3'd0, 3'd6, 3'd0, 3'd0}; wvalid = 4'b0000;
        tick();
        idle();
        tick();
        chk_state("wk_novalid", 4'd1, 2'b00, 1'b1);
        wdest = {3'd0, 3'd6, 3'd0, 3'd0}; wvalid = 4'b0100;
        tick();
        chk_state("wk_n1", 4'd1, 2'b00, 1'b1);
        idle();
        tick();
        chk_state("wk_n2", 4'd0, 2'b01, 1'b1);
        chk("wk_inst0", 64'(oinst[0 +: W]), 64'(wu | 25'd1));

        // Kill: killed pick leaves its port idle (inst held), incoming match dropped
        k0 = mk(7'h40, 3'b010, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        k1 = mk(7'h41, 3'b001, 3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        k2 = mk(7'h42, 3'b010, 3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        idle(); en = 1'b1; inst = {zero_u, zero_u, k1, k0};
        tick();
        chk_state("kill_disp", 4'd2, 2'b00, 1'b1);
        idle(); en = 1'b1; inst = {zero_u, zero_u, zero_u, k2}; brkill = 3'b010;
        tick();
        chk_state("kill_edge", 4'd0, 2'b10, 1'b1);
        chk("kill_inst1", 64'(oinst[W +: W]), 64'(k1));
        chk("kill_inst0_held", 64'(oinst[0 +: W]), 64'(wu | 25'd1));
        idle();
        tick();
        chk_state("kill_after", 4'd0, 2'b00, 1'b1);

`ifdef IQ_BRCLEAR_EN
        // Branch clear: resolved bit no longer kills; issued mask is cleared
        cu = mk(7'h60, 3'b011, 3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0);
        idle(); en = 1'b1; inst = {zero_u, zero_u, zero_u, cu}; brclr = 3'b001;
        tick();
        chk_state("clr_disp", 4'd1, 2'b00, 1'b1);
        idle(); brkill = 3'b001;
        tick();
        chk_state("clr_kill", 4'd1, 2'b00, 1'b1);
        idle(); wdest = {3'd0, 3'd0, 3'd0, 3'd7}; wvalid = 4'b0001;
        tick();
        idle();
        tick();
        chk_state("clr_issue", 4'd0, 2'b01, 1'b1);
        chk("clr_inst0", 64'(oinst[0 +: W]), 64'(mk(7'h60, 3'b010, 3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 1'b1)));
`else
        cu = '0;
`endif

        // Async reset mid-run with 5 slots held
        r0 = mk(7'h70, 3'b000, 3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0);
        idle(); en = 1'b1; inst = {r0, r0, r0, r0};
        tick();
        idle(); en = 1'b1; inst = {zero_u, zero_u, zero_u, r0};
        tick();
        chk_state("rst_held", 4'd5, 2'b00, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk_state("rst_async", 4'd0, 2'b00, 1'b1);
        rst = 1'b0;
        wdest = {3'd0, 3'd0, 3'd0, 3'd7}; wvalid = 4'b0001;
        tick();
        idle();
        tick();
        chk_state("rst_after", 4'd0, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
